// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_BUS      = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int LANES = 4;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Memory bus between the sequencer (master) and the memory fabric (slave).
interface mc_sequencer_if;
  import mc_pkg::*;

  // mem_req is held with stable addr/we/be/wdata until a cycle where
  // mem_ready=1; that cycle completes the transfer (mem_err=1 marks it failed).
  logic             mem_req;
  logic             mem_we;
  logic [LANES-1:0] mem_be;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic             mem_err;
  logic [31:0]      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_err, mem_rdata
  );
endinterface

// File: rtl/mc_sequencer_lane_align.sv
// Big-endian byte-lane placement for stores and lane extraction/extension for loads.
module lane_align
  import mc_pkg::*;
(
  input  logic [1:0]       off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [31:0]      st_data_i,
  input  logic [31:0]      ld_word_i,
  output logic [LANES-1:0] be_o,
  output logic [31:0]      st_word_o,
  output logic [31:0]      ld_data_o
);

  logic [4:0]  sh;
  logic [31:0] ld_sh;

  // Offset 0 is the most significant lane, so shifting left by 8*off
  // brings the addressed bytes to the top of the word.
  assign sh    = {off_i, 3'b000};
  assign ld_sh = ld_word_i << sh;

  always_comb begin
    be_o      = 4'hF;
    st_word_o = st_data_i;
    ld_data_o = ld_word_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o      = 4'b1000 >> off_i;
        st_word_o = {st_data_i[7:0], 24'h0} >> sh;
        ld_data_o = {{24{!unsigned_i & ld_sh[31]}}, ld_sh[31:24]};
      end
      SIZE_HALF: begin
        be_o      = 4'b1100 >> off_i;
        st_word_o = {st_data_i[15:0], 16'h0} >> sh;
        ld_data_o = {{16{!unsigned_i & ld_sh[31]}}, ld_sh[31:16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: PC, IR, FSM, bus handshake, MMIO writes.
// Define SINGLE_STEP_EN to return to IDLE after every WRITEBACK.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h0007_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  mc_sequencer_if.master  bus,
  output logic [XLEN-1:0] instr_o,
  input  logic            dec_err_i,
  input  logic            dec_halt_i,
  input  logic            dec_load_i,
  input  logic            dec_store_i,
  input  logic            dec_unsigned_i,
  input  logic            dec_jump_i,
  input  logic            dec_jalr_i,
  input  logic            dec_branch_i,
  input  logic            dec_rd_we_i,
  input  logic            dec_a_pc_i,
  input  logic            dec_b_imm_i,
  input  logic [1:0]      dec_size_i,
  input  logic [XLEN-1:0] dec_imm_i,
  input  logic [XLEN-1:0] rv1_i,
  input  logic [XLEN-1:0] rv2_i,
  input  logic [XLEN-1:0] alu_y_i,
  input  logic            br_taken_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic            rf_we_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            mmio_we_o,
  output logic [XLEN-1:0] mmio_addr_o,
  output logic [XLEN-1:0] mmio_wdata_o,
  output logic [2:0]      state_o,
  output logic [XLEN-1:0] pc_o,
  output logic [1:0]      fault_cause_o
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q;
  logic [31:0]      pc_q, instr_q, alu_a_q, alu_b_q, ea_q, ld_q;
  logic [31:0]      rf_wdata_q, mmio_addr_q, mmio_wdata_q, mem_addr_q, mem_wdata_q;
  logic             rf_we_q, mmio_we_q, mem_req_q, mem_we_q;
  logic [LANES-1:0] mem_be_q;
  logic [1:0]       cause_q;
  logic [TW-1:0]    tmo_q;

  logic [31:0]      pc_plus4_d, pc_d, rf_wdata_d, la_word, la_ld;
  logic [LANES-1:0] la_be;
  logic [1:0]       la_off;
  logic             xfer_done, xfer_bad;

  assign pc_plus4_d = pc_q + 32'd4;
  assign rf_wdata_d = dec_jump_i ? pc_plus4_d : (dec_load_i ? ld_q : ea_q);

  always_comb begin
    pc_d = pc_plus4_d;
    if (dec_jump_i && !dec_jalr_i)        pc_d = pc_q + dec_imm_i;
    else if (dec_jalr_i)                  pc_d = (rv1_i + dec_imm_i) & ~32'd1;
    else if (dec_branch_i && br_taken_i)  pc_d = pc_q + dec_imm_i;
  end

  // Ready wins over a simultaneous timeout; error wins over ready.
  assign xfer_done = mem_req_q & bus.mem_ready & !bus.mem_err;
  assign xfer_bad  = mem_req_q & ((bus.mem_ready & bus.mem_err) |
                     (!bus.mem_ready & (MEM_TIMEOUT != 0) & (tmo_q == TW'(MEM_TIMEOUT - 1))));

  // Stores are placed while leaving EXECUTE; loads are extracted during MEM.
  assign la_off = (state_q == ST_EXECUTE) ? alu_y_i[1:0] : ea_q[1:0];

  lane_align u_lane_align (
    .off_i      (la_off),
    .size_i     (dec_size_i),
    .unsigned_i (dec_unsigned_i),
    .st_data_i  (rv2_i),
    .ld_word_i  (bus.mem_rdata),
    .be_o       (la_be),
    .st_word_o  (la_word),
    .ld_data_o  (la_ld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;      pc_q <= RESET_PC;     instr_q <= '0;
      alu_a_q <= '0;           alu_b_q <= '0;        ea_q <= '0;
      ld_q <= '0;              rf_we_q <= 1'b0;      rf_wdata_q <= '0;
      mmio_we_q <= 1'b0;       mmio_addr_q <= '0;    mmio_wdata_q <= '0;
      mem_req_q <= 1'b0;       mem_we_q <= 1'b0;     mem_be_q <= '0;
      mem_addr_q <= '0;        mem_wdata_q <= '0;    cause_q <= CAUSE_NONE;
      tmo_q <= '0;
    end else begin
      rf_we_q   <= 1'b0;
      mmio_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q    <= ST_FETCH;
          mem_req_q  <= (pc_q[1:0] == 2'b00);
          mem_we_q   <= 1'b0;
          mem_be_q   <= 4'hF;
          mem_addr_q <= pc_q;
          tmo_q      <= '0;
        end
        ST_FETCH: begin
          if (pc_q[1:0] != 2'b00) begin
            state_q <= ST_FAULT;
            cause_q <= CAUSE_MISALIGN;
          end else if (xfer_bad) begin
            state_q   <= ST_FAULT;
            cause_q   <= CAUSE_BUS;
            mem_req_q <= 1'b0;
          end else if (xfer_done) begin
            state_q   <= ST_DECODE;
            instr_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_halt_i) begin
            state_q <= ST_HALT;
          end else if (dec_err_i) begin
            state_q <= ST_FAULT;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            alu_a_q <= dec_a_pc_i ? pc_q : rv1_i;
            alu_b_q <= dec_b_imm_i ? dec_imm_i : rv2_i;
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          ea_q <= alu_y_i;
          if (!(dec_load_i || dec_store_i)) begin
            state_q <= ST_WRITEBACK;
          end else if (misaligned(dec_size_i, alu_y_i[1:0])) begin
            state_q <= ST_FAULT;
            cause_q <= CAUSE_MISALIGN;
          end else begin
            state_q <= ST_MEM;
            if (alu_y_i >= MMIO_BASE) begin
              mmio_we_q    <= dec_store_i;
              mmio_addr_q  <= alu_y_i;
              mmio_wdata_q <= rv2_i;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= dec_store_i;
              mem_be_q    <= la_be;
              mem_addr_q  <= {alu_y_i[31:2], 2'b00};
              mem_wdata_q <= la_word;
              tmo_q       <= '0;
            end
          end
        end
        ST_MEM: begin
          if (!mem_req_q) begin
            ld_q    <= '0;
            state_q <= ST_WRITEBACK;
          end else if (xfer_bad) begin
            state_q   <= ST_FAULT;
            cause_q   <= CAUSE_BUS;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else if (xfer_done) begin
            ld_q      <= la_ld;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_WRITEBACK;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WRITEBACK: begin
          rf_we_q    <= dec_rd_we_i;
          rf_wdata_q <= rf_wdata_d;
          pc_q       <= pc_d;
`ifdef SINGLE_STEP_EN
          state_q    <= ST_IDLE;
`else
          state_q    <= ST_FETCH;
          mem_req_q  <= (pc_d[1:0] == 2'b00);
          mem_we_q   <= 1'b0;
          mem_be_q   <= 4'hF;
          mem_addr_q <= pc_d;
          tmo_q      <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign instr_o       = instr_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign rf_we_o       = rf_we_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign mmio_we_o     = mmio_we_q;
  assign mmio_addr_o   = mmio_addr_q;
  assign mmio_wdata_o  = mmio_wdata_q;
  assign state_o       = state_q;
  assign pc_o          = pc_q;
  assign fault_cause_o = cause_q;

endmodule
